// File: rtl/qupls4_rf_rport_scheduler_pkg.sv
// Shared types and build constants for the register-file read-port scheduler.
// Holds the default geometry (entries, operands, ports, read latency, age limit),
// the physical register number type and the read-port tag carried alongside RF data.
// Optional feature macro used by the files that import this package:
//   QUPLS4_RPORT_DEDUP_EN - slots naming the same pRn in one cycle share a port.
package qupls4_rf_rport_scheduler_pkg;

  localparam int RPORT_NREQ    = 4;
  localparam int RPORT_NOPER   = 3;
  localparam int RPORT_NSLOT   = RPORT_NREQ * RPORT_NOPER;
  localparam int RPORT_NRPORT  = 4;
  localparam int RPORT_RDLAT   = 1;
  localparam int RPORT_AGE_MAX = 15;
  localparam int RPORT_SLOTW   = $clog2(RPORT_NSLOT);
  localparam int PREGW         = 9;

  typedef logic [PREGW-1:0]       pregno_t;
  typedef logic [RPORT_SLOTW-1:0] slotno_t;

  // Travels down the tag pipeline so RF data can be steered to its slot.
  typedef struct packed {
    logic    v;
    slotno_t slot;
  } rport_tag_t;

endpackage

// File: rtl/qupls4_rf_rport_scheduler_if.sv
// Request/grant and read-port bus between reservation-station operand slots,
// the read-port scheduler and the register file.
//   req_v_i / req_preg_i : per-slot operand request and wanted pRn
//   gnt_o                : per-slot one-cycle grant pulse
//   rport_v_o/rport_preg_o : read-port enable and address
//   rd_tag_v_o / rd_tag_o  : slot owning each port's returning data
//   rd_tag_mask_o          : all slots sharing a port (QUPLS4_RPORT_DEDUP_EN only)
// Modport slave is the scheduler, master is the requester/RF side.
interface qupls4_rf_rport_scheduler_if
  import qupls4_rf_rport_scheduler_pkg::*;
#(
  parameter int NSLOT  = RPORT_NSLOT,
  parameter int NRPORT = RPORT_NRPORT
);
  localparam int SLOTW = $clog2(NSLOT);

  logic    [NSLOT-1:0]             req_v_i;
  pregno_t [NSLOT-1:0]             req_preg_i;
  logic    [NSLOT-1:0]             gnt_o;
  logic    [NRPORT-1:0]            rport_v_o;
  pregno_t [NRPORT-1:0]            rport_preg_o;
  logic    [NRPORT-1:0]            rd_tag_v_o;
  logic    [NRPORT-1:0][SLOTW-1:0] rd_tag_o;
`ifdef QUPLS4_RPORT_DEDUP_EN
  logic    [NRPORT-1:0][NSLOT-1:0] rd_tag_mask_o;

  modport slave  (input  req_v_i, req_preg_i,
                  output gnt_o, rport_v_o, rport_preg_o, rd_tag_v_o, rd_tag_o, rd_tag_mask_o);
  modport master (output req_v_i, req_preg_i,
                  input  gnt_o, rport_v_o, rport_preg_o, rd_tag_v_o, rd_tag_o, rd_tag_mask_o);
`else
  modport slave  (input  req_v_i, req_preg_i,
                  output gnt_o, rport_v_o, rport_preg_o, rd_tag_v_o, rd_tag_o);
  modport master (output req_v_i, req_preg_i,
                  input  gnt_o, rport_v_o, rport_preg_o, rd_tag_v_o, rd_tag_o);
`endif

endinterface

// File: rtl/qupls4_rf_rport_scheduler_rr_pick_n.sv
// qupls4_rr_pick_n: combinational picker returning up to N set bits of an M-bit
// vector, scanned in rotating order starting at rot_i.
//   vec_i : candidate bits       rot_i : first index examined
//   idx_o : pick indices, idx_o[0] is the first pick
//   cnt_o : number of valid entries in idx_o
module qupls4_rr_pick_n #(
  parameter int M = 12,
  parameter int N = 4
)(
  input  logic [M-1:0]                vec_i,
  input  logic [$clog2(M)-1:0]        rot_i,
  output logic [N-1:0][$clog2(M)-1:0] idx_o,
  output logic [$clog2(N+1)-1:0]      cnt_o
);
  localparam int IW = $clog2(M);

  // Walk every index once from rot_i, wrapping, and keep the first N hits.
  always_comb begin
    int s;
    s     = 0;
    idx_o = '0;
    cnt_o = '0;
    for (int i = 0; i < M; i++) begin
      s = int'(rot_i) + i;
      if (s >= M) s = s - M;
      if (vec_i[s] && int'(cnt_o) < N) begin
        idx_o[cnt_o] = IW'(s);
        cnt_o        = cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: rtl/qupls4_rf_rport_scheduler.sv
// Shares NRPORT register-file read ports among reservation-station operand slots.
// Aged slots (age == AGE_MAX) win first, lowest index first; remaining ports go
// round-robin from the rr pointer. Port addresses and grants are registered, and a
// tag pipeline re-aligns each port's owning slot with RF data RDLAT cycles later.
// Ports: clk, rst (sync, active-high), stall_i, flush_i, busy_o, and the
// qupls4_rf_rport_scheduler_if.slave bus carrying requests, grants, ports and tags.
// Optional: QUPLS4_RPORT_DEDUP_EN merges picks naming the same pRn onto one port
// and adds rd_tag_mask_o.
module qupls4_rf_rport_scheduler
  import qupls4_rf_rport_scheduler_pkg::*;
#(
  parameter int NREQ    = RPORT_NREQ,
  parameter int NOPER   = RPORT_NOPER,
  parameter int NRPORT  = RPORT_NRPORT,
  parameter int RDLAT   = RPORT_RDLAT,
  parameter int AGE_MAX = RPORT_AGE_MAX
)(
  input  logic clk,
  input  logic rst,
  input  logic stall_i,
  input  logic flush_i,
  output logic busy_o,
  qupls4_rf_rport_scheduler_if.slave bus
);
  localparam int NSLOT = NREQ * NOPER;
  localparam int IW    = $clog2(NSLOT);
  localparam int CW    = $clog2(NRPORT + 1);
  localparam int AGEW  = $clog2(AGE_MAX + 1);

  logic [NSLOT-1:0]             elig, aged, rrVec;
  logic [NRPORT-1:0][IW-1:0]    ageIdx, rrIdx, pickSlot;
  logic [CW-1:0]                ageCnt, rrCnt;
  logic [NRPORT-1:0]            pickV;
  logic                         rrAny;
  logic [IW-1:0]                lastRr;

  logic [NSLOT-1:0]             gnt_q, gnt_d;
  logic [NRPORT-1:0]            rport_v_q, rport_v_d;
  pregno_t [NRPORT-1:0]         rport_preg_q, rport_preg_d;
  logic [NRPORT-1:0][IW-1:0]    portSlot_q, portSlot_d;
  logic [IW-1:0]                rr_q, rr_d;
  logic [NSLOT-1:0][AGEW-1:0]   age_q, age_d;
  rport_tag_t [RDLAT-1:0][NRPORT-1:0] tag_q;
  logic                         tagInFlight;
`ifdef QUPLS4_RPORT_DEDUP_EN
  logic [NRPORT-1:0][NSLOT-1:0]            portMask_q, portMask_d;
  logic [RDLAT-1:0][NRPORT-1:0][NSLOT-1:0] tagMask_q;
`endif

  // A slot granted last cycle is masked so a late-dropping requester is not granted twice.
  always_comb begin
    elig  = bus.req_v_i & ~gnt_q;
    aged  = '0;
    for (int s = 0; s < NSLOT; s++)
      aged[s] = elig[s] && (age_q[s] == AGEW'(AGE_MAX));
    rrVec = elig & ~aged;
  end

  qupls4_rr_pick_n #(.M(NSLOT), .N(NRPORT)) uAgePick (
    .vec_i(aged), .rot_i('0), .idx_o(ageIdx), .cnt_o(ageCnt));

  qupls4_rr_pick_n #(.M(NSLOT), .N(NRPORT)) uRrPick (
    .vec_i(rrVec), .rot_i(rr_q), .idx_o(rrIdx), .cnt_o(rrCnt));

  // Age picks take the first ports; round-robin picks fill whatever is left.
  // Only round-robin picks move the rr pointer.
  always_comb begin
    pickV    = '0;
    pickSlot = '0;
    rrAny    = 1'b0;
    lastRr   = '0;
    if (!stall_i && !flush_i) begin
      for (int k = 0; k < NRPORT; k++) begin
        if (k < int'(ageCnt)) begin
          pickV[k]    = 1'b1;
          pickSlot[k] = ageIdx[k];
        end else if ((k - int'(ageCnt)) < int'(rrCnt)) begin
          pickV[k]    = 1'b1;
          pickSlot[k] = rrIdx[k - int'(ageCnt)];
          rrAny       = 1'b1;
          lastRr      = rrIdx[k - int'(ageCnt)];
        end
      end
    end
    rr_d = rrAny ? ((lastRr == IW'(NSLOT - 1)) ? '0 : lastRr + 1'b1) : rr_q;
  end

`ifdef QUPLS4_RPORT_DEDUP_EN
  // A pick whose pRn already sits on an earlier port joins that port's mask;
  // the tag reports the lowest slot in the mask.
  always_comb begin
    int  nPort;
    int  match;
    logic hit;
    nPort        = 0;
    match        = 0;
    hit          = 1'b0;
    gnt_d        = '0;
    rport_v_d    = '0;
    rport_preg_d = '0;
    portSlot_d   = '0;
    portMask_d   = '0;
    for (int k = 0; k < NRPORT; k++) begin
      if (pickV[k]) begin
        gnt_d[pickSlot[k]] = 1'b1;
        hit   = 1'b0;
        match = 0;
        for (int p = 0; p < NRPORT; p++) begin
          if (!hit && rport_v_d[p] && rport_preg_d[p] == bus.req_preg_i[pickSlot[k]]) begin
            hit   = 1'b1;
            match = p;
          end
        end
        if (hit) begin
          portMask_d[match][pickSlot[k]] = 1'b1;
        end else begin
          rport_v_d[nPort]               = 1'b1;
          rport_preg_d[nPort]            = bus.req_preg_i[pickSlot[k]];
          portMask_d[nPort][pickSlot[k]] = 1'b1;
          nPort                          = nPort + 1;
        end
      end
    end
    for (int p = 0; p < NRPORT; p++)
      for (int s = NSLOT - 1; s >= 0; s--)
        if (portMask_d[p][s]) portSlot_d[p] = IW'(s);
  end
`else
  // Port k simply carries the k-th pick.
  always_comb begin
    gnt_d        = '0;
    rport_v_d    = '0;
    rport_preg_d = '0;
    portSlot_d   = '0;
    for (int k = 0; k < NRPORT; k++) begin
      if (pickV[k]) begin
        gnt_d[pickSlot[k]] = 1'b1;
        rport_v_d[k]       = 1'b1;
        rport_preg_d[k]    = bus.req_preg_i[pickSlot[k]];
        portSlot_d[k]      = pickSlot[k];
      end
    end
  end
`endif

  // Ages keep counting through stalls so a slot starved by a long stall wins on release.
  always_comb begin
    for (int s = 0; s < NSLOT; s++) begin
      if (flush_i || !bus.req_v_i[s] || gnt_d[s])
        age_d[s] = '0;
      else if (age_q[s] != AGEW'(AGE_MAX))
        age_d[s] = age_q[s] + 1'b1;
      else
        age_d[s] = age_q[s];
    end
  end

  // Stage 0 of the tag pipeline is fed from the registered port outputs, so the last
  // stage lines up with RF data RDLAT cycles after rport_v_o. Flush empties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q        <= '0;
      rport_v_q    <= '0;
      rport_preg_q <= '0;
      portSlot_q   <= '0;
      rr_q         <= '0;
      age_q        <= '0;
      tag_q        <= '0;
`ifdef QUPLS4_RPORT_DEDUP_EN
      portMask_q   <= '0;
      tagMask_q    <= '0;
`endif
    end else begin
      gnt_q        <= gnt_d;
      rport_v_q    <= rport_v_d;
      rport_preg_q <= rport_preg_d;
      portSlot_q   <= portSlot_d;
      rr_q         <= rr_d;
      age_q        <= age_d;
`ifdef QUPLS4_RPORT_DEDUP_EN
      portMask_q   <= portMask_d;
`endif
      if (flush_i) begin
        tag_q <= '0;
`ifdef QUPLS4_RPORT_DEDUP_EN
        tagMask_q <= '0;
`endif
      end else begin
        for (int k = 0; k < NRPORT; k++) begin
          tag_q[0][k].v    <= rport_v_q[k];
          tag_q[0][k].slot <= portSlot_q[k];
        end
        for (int i = 1; i < RDLAT; i++)
          tag_q[i] <= tag_q[i-1];
`ifdef QUPLS4_RPORT_DEDUP_EN
        tagMask_q[0] <= portMask_q;
        for (int i = 1; i < RDLAT; i++)
          tagMask_q[i] <= tagMask_q[i-1];
`endif
      end
    end
  end

  // Drive the bus from the registered state and summarise activity for busy_o.
  always_comb begin
    tagInFlight = 1'b0;
    for (int i = 0; i < RDLAT; i++)
      for (int k = 0; k < NRPORT; k++)
        tagInFlight = tagInFlight | tag_q[i][k].v;
    for (int k = 0; k < NRPORT; k++) begin
      bus.rd_tag_v_o[k] = tag_q[RDLAT-1][k].v;
      bus.rd_tag_o[k]   = tag_q[RDLAT-1][k].slot;
    end
  end

  assign bus.gnt_o        = gnt_q;
  assign bus.rport_v_o    = rport_v_q;
  assign bus.rport_preg_o = rport_preg_q;
`ifdef QUPLS4_RPORT_DEDUP_EN
  assign bus.rd_tag_mask_o = tagMask_q[RDLAT-1];
`endif
  assign busy_o = (|bus.req_v_i) | (|rport_v_q) | tagInFlight;

endmodule
